// File: rtl/imm_packer.sv
// Immediate packer: scatters a signed immediate into the fields of a RISC-V
// instruction format, range-checks it, and delivers the word through a 2-stage valid/ready pipe.
module imm_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  imm_type,
    input  logic [31:0] imm,
    input  logic [31:0] base_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic        range_err,
    output logic [7:0]  err_count
);

    typedef enum logic [2:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b001,
        FMT_B = 3'b010,
        FMT_U = 3'b011,
        FMT_J = 3'b100
    } fmt_e;

    logic        s1_v_q, s1_v_d;
    logic [2:0]  s1_type_q, s1_type_d;
    logic [31:0] s1_imm_q, s1_imm_d;
    logic [31:0] s1_base_q, s1_base_d;

    logic        s2_v_q, s2_v_d;
    logic [31:0] s2_instr_q, s2_instr_d;
    logic        s2_err_q, s2_err_d;

    logic [7:0]  err_cnt_q, err_cnt_d;

    logic        s2_ready;
    logic        s1_ready;
    logic [31:0] s1_instr;
    logic        s1_err;
    logic        fits12;
    logic        fits13;
    logic        fits21;

    // S2 can take a word when empty or draining; S1 when empty or moving into S2.
    assign s2_ready = !s2_v_q || out_ready;
    assign s1_ready = !s1_v_q || s2_ready;
    assign in_ready = s1_ready;

    assign fits12 = (&s1_imm_q[31:11]) || !(|s1_imm_q[31:11]);
    assign fits13 = (&s1_imm_q[31:12]) || !(|s1_imm_q[31:12]);
    assign fits21 = (&s1_imm_q[31:20]) || !(|s1_imm_q[31:20]);

    always_comb begin
        s1_instr = s1_base_q;
        s1_err   = 1'b1;
        case (s1_type_q)
            FMT_I: begin
                s1_instr[31:20] = s1_imm_q[11:0];
                s1_err          = !fits12;
            end
            FMT_S: begin
                s1_instr[31:25] = s1_imm_q[11:5];
                s1_instr[11:7]  = s1_imm_q[4:0];
                s1_err          = !fits12;
            end
            FMT_B: begin
                s1_instr[31]    = s1_imm_q[12];
                s1_instr[30:25] = s1_imm_q[10:5];
                s1_instr[11:8]  = s1_imm_q[4:1];
                s1_instr[7]     = s1_imm_q[11];
                s1_err          = !fits13 || s1_imm_q[0];
            end
            FMT_U: begin
                s1_instr[31:12] = s1_imm_q[31:12];
                s1_err          = |s1_imm_q[11:0];
            end
            FMT_J: begin
                s1_instr[31]    = s1_imm_q[20];
                s1_instr[30:21] = s1_imm_q[10:1];
                s1_instr[20]    = s1_imm_q[11];
                s1_instr[19:12] = s1_imm_q[19:12];
                s1_err          = !fits21 || s1_imm_q[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        s1_v_d     = s1_v_q;
        s1_type_d  = s1_type_q;
        s1_imm_d   = s1_imm_q;
        s1_base_d  = s1_base_q;
        s2_v_d     = s2_v_q;
        s2_instr_d = s2_instr_q;
        s2_err_d   = s2_err_q;
        err_cnt_d  = err_cnt_q;

        if (s1_ready) begin
            s1_v_d = in_valid;
            if (in_valid) begin
                s1_type_d = imm_type;
                s1_imm_d  = imm;
                s1_base_d = base_instr;
            end
        end

        if (s2_ready) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) begin
                s2_instr_d = s1_instr;
                s2_err_d   = s1_err;
            end
        end

        if (s2_v_q && out_ready && s2_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v_q     <= 1'b0;
            s1_type_q  <= '0;
            s1_imm_q   <= '0;
            s1_base_q  <= '0;
            s2_v_q     <= 1'b0;
            s2_instr_q <= '0;
            s2_err_q   <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_type_q  <= s1_type_d;
            s1_imm_q   <= s1_imm_d;
            s1_base_q  <= s1_base_d;
            s2_v_q     <= s2_v_d;
            s2_instr_q <= s2_instr_d;
            s2_err_q   <= s2_err_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign out_valid = s2_v_q;
    assign instr     = s2_instr_q;
    assign range_err = s2_err_q;
    assign err_count = err_cnt_q;

endmodule

// File: tb/tb_imm_packer.sv
// Bench for imm_packer: directed spec vectors plus randomized traffic checked
// against an arithmetic reference model and an in-order scoreboard.
module tb_imm_packer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  imm_type;
    logic [31:0] imm;
    logic [31:0] base_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        range_err;
    logic [7:0]  err_count;

    imm_packer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imm_type   (imm_type),
        .imm        (imm),
        .base_instr (base_instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .instr      (instr),
        .range_err  (range_err),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_mis = 0;
    int unsigned m_cnt = 0;
    logic [32:0] sb_q[$];
    logic [31:0] cur_instr;
    logic        cur_err;
    logic        prev_stall = 1'b0;
    logic [32:0] prev_out  = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference encoder built from the field rules with shifts and masks; range is judged on the signed value.
    function automatic logic [32:0] model(input logic [2:0] t, input logic [31:0] v, input logic [31:0] b);
        int          s;
        logic [31:0] w;
        logic        e;
        s = $signed(v);
        w = b;
        e = 1'b1;
        case (t)
            3'd0: begin
                w = (b & 32'h000F_FFFF) | (v << 20);
                e = !(s >= -2048 && s <= 2047);
            end
            3'd1: begin
                w = (b & 32'h01FF_F07F) | (((v >> 5) & 32'h7F) << 25) | ((v & 32'h1F) << 7);
                e = !(s >= -2048 && s <= 2047);
            end
            3'd2: begin
                w = (b & 32'h01FF_F07F) | (((v >> 12) & 32'h1) << 31) | (((v >> 5) & 32'h3F) << 25)
                  | (((v >> 1) & 32'hF) << 8) | (((v >> 11) & 32'h1) << 7);
                e = !(s >= -4096 && s <= 4095 && (v & 32'h1) == 0);
            end
            3'd3: begin
                w = (b & 32'h0000_0FFF) | (v & 32'hFFFF_F000);
                e = (v & 32'hFFF) != 0;
            end
            3'd4: begin
                w = (b & 32'h0000_0FFF) | (((v >> 20) & 32'h1) << 31) | (((v >> 1) & 32'h3FF) << 21)
                  | (((v >> 11) & 32'h1) << 20) | (((v >> 12) & 32'hFF) << 12);
                e = !(s >= -(1 << 20) && s <= (1 << 20) - 1 && (v & 32'h1) == 0);
            end
            default: ;
        endcase
        return {e, w};
    endfunction

    // One clock: check outputs, advance across the edge, update scoreboard/model.
    task automatic step();
        logic        acc;
        logic        dlv;
        logic [32:0] e;
        #1;
        acc = in_valid && in_ready && !reset;
        dlv = out_valid && out_ready && !reset;
        if (!reset) begin
            chk("err_count", 64'(err_count), 64'(m_cnt));
            if (out_valid) begin
                if (sb_q.size() == 0) chk("spurious_out_valid", 64'(out_valid), 64'd0);
                else begin
                    chk("instr", 64'(instr), 64'(sb_q[0][31:0]));
                    chk("range_err", 64'(range_err), 64'(sb_q[0][32]));
                end
                if (prev_stall) chk("stall_hold", 64'({range_err, instr}), 64'(prev_out));
            end
        end
        prev_stall = out_valid && !out_ready && !reset;
        prev_out   = {range_err, instr};
        @(posedge clk);
        if (reset) begin
            sb_q.delete();
            m_cnt = 0;
        end else begin
            if (acc) sb_q.push_back({cur_err, cur_instr});
            if (dlv && sb_q.size() != 0) begin
                e = sb_q.pop_front();
                if (e[32] && m_cnt < 255) m_cnt++;
            end
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] t, input logic [31:0] v, input logic [31:0] b,
                         input logic [31:0] ei, input logic ee);
        logic done;
        in_valid   = 1'b1;
        imm_type   = t;
        imm        = v;
        base_instr = b;
        cur_instr  = ei;
        cur_err    = ee;
        done       = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            #1;
            done = in_ready;
            step();
        end
        if (!done) chk("accept_timeout", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 50 && sb_q.size() != 0; i++) step();
        chk("drain_left", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        logic [32:0] m;
        logic        have;
        int unsigned sel;
        reset = 1'b1; in_valid = 1'b0; imm_type = '0; imm = '0; base_instr = '0; out_ready = 1'b0;
        cur_instr = '0; cur_err = 1'b0;
        @(negedge clk);
        step();
        step();
        reset = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_range_err", 64'(range_err), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        // I-type with latency check
        out_ready = 1'b1;
        drive(3'd0, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0);
        #1 chk("lat_edge1", 64'(out_valid), 64'd0);
        step();
        #1 chk("lat_edge2", 64'(out_valid), 64'd1);
        step();

        drive(3'd1, 32'd8, 32'h0000_2023, 32'h0000_2423, 1'b0);
        drive(3'd3, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0);
        drive(3'd3, 32'h1234_5001, 32'h0000_0037, 32'h1234_5037, 1'b1);
        drain();
        step();
        chk("err_count_one", 64'(err_count), 64'd1);
        drive(3'd2, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0);
        drive(3'd4, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 1'b0);
        drive(3'd2, 32'd3, 32'h0000_0063, 32'h0000_0163, 1'b1);
        drive(3'd0, 32'd2048, 32'h0000_0013, 32'h8000_0013, 1'b1);
        drive(3'd7, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        drain();

        // backpressure: capacity two, then three in order, back to back
        out_ready = 1'b0;
        m = model(3'd0, 32'd1, 32'h0000_0093); drive(3'd0, 32'd1, 32'h0000_0093, m[31:0], m[32]);
        m = model(3'd1, 32'd2, 32'h0000_2023); drive(3'd1, 32'd2, 32'h0000_2023, m[31:0], m[32]);
        m = model(3'd3, 32'h0000_3000, 32'h0000_0037);
        in_valid = 1'b1; imm_type = 3'd3; imm = 32'h0000_3000; base_instr = 32'h0000_0037;
        cur_instr = m[31:0]; cur_err = m[32];
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_in_ready_low", 64'(in_ready), 64'd0);
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("bp_release_valid", 64'(out_valid), 64'd1);
            step();
            in_valid = 1'b0;
        end
        #1 chk("bp_empty_after", 64'(out_valid), 64'd0);
        drain();

        // reset with both stages full discards everything
        out_ready = 1'b0;
        m = model(3'd2, 32'd5, 32'h0000_0063); drive(3'd2, 32'd5, 32'h0000_0063, m[31:0], m[32]);
        m = model(3'd7, 32'd0, 32'h1111_1111); drive(3'd7, 32'd0, 32'h1111_1111, m[31:0], m[32]);
        reset = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        step();
        reset = 1'b0; in_valid = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_err_count", 64'(err_count), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 5; i++) step();

        // randomized traffic
        have = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!have || (in_valid && in_ready)) begin
                imm_type   = 3'($urandom_range(0, 7));
                sel        = $urandom_range(0, 3);
                imm        = (sel == 0) ? $urandom() :
                             (sel == 1) ? 32'($urandom_range(0, 8191)) - 32'd4096 :
                             (sel == 2) ? ($urandom() & 32'hFFFF_F000) :
                                          32'($urandom_range(0, 4194303)) - 32'd2097152;
                base_instr = $urandom();
                m          = model(imm_type, imm, base_instr);
                cur_instr  = m[31:0];
                cur_err    = m[32];
                have       = 1'b1;
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            #1;
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // saturation of the error counter
        for (int i = 0; i < 260; i++) begin
            drive(3'd5, 32'(i), 32'h0000_0013, 32'h0000_0013, 1'b1);
        end
        drain();
        step();
        chk("err_count_sat", 64'(err_count), 64'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imm_packer.md
# imm_packer

Immediate packer for the multicycle RISC-V core: the inverse of the immediate extender. Takes a 32-bit signed immediate, an instruction format and a base instruction word. Scatters the immediate bits into the format's instruction fields, range-checks the value, and delivers the assembled 32-bit instruction through a 2-stage valid/ready pipeline. Used by the boot/test program generator and by the self-check path that re-encodes decoded instructions.

## Interface
- No parameters.
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  input word present
- in_ready  out  1  packer can accept this cycle
- imm_type  in  3  000 I, 001 S, 010 B, 011 U, 100 J, 101–111 invalid
- imm  in  32  signed immediate (byte offset for B/J)
- base_instr  in  32  opcode/rd/rs1/rs2/funct source; immediate field bits ignored
- out_valid  out  1  assembled instruction present
- out_ready  in  1  consumer accepts this cycle
- instr  out  32  assembled instruction
- range_err  out  1  immediate not representable in imm_type (or invalid type)
- err_count  out  8  saturating count of accepted outputs with range_err=1

## Operation
- Transfer on a port occurs when valid and ready are both high at a rising edge.
- Stage 1 (S1) registers imm_type, imm and base_instr, and computes range_err. Stage 2 (S2) registers the assembled instr and range_err; S2 drives the outputs.
- Field placement (non-listed bits copied from base_instr):
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - U: [31:12]=imm[31:12].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
  - invalid: instr=base_instr.
- Range rules (range_err=1 if violated):
  - I/S: imm[31:11] all equal.
  - B: imm[31:12] all equal and imm[0]=0.
  - U: imm[11:0]=0.
  - J: imm[31:20] all equal and imm[0]=0.
  - invalid type: always error.
- On error the word is still delivered, with truncated fields per the placement rules; it is never dropped.
- Ordering: strict FIFO, no reordering or duplication.
- err_count increments on each output transfer with range_err=1. It saturates at 255 and does not wrap.

## Timing
- Reset: S1/S2 valid flags cleared, out_valid=0, instr=0, range_err=0, err_count=0. Reset takes precedence over any simultaneous transfer.
- Reset mid-operation discards all in-flight words.
- Latency: a word accepted at edge k is in S1 after k, in S2 after k+1. out_valid is high in the cycle after edge k+1 if there is no stall.
- Flow rules:
  - S2 loads from S1 when S2 is empty or draining (out_valid & out_ready).
  - S1 loads when S1 is empty or moving into S2.
  - in_ready = !s1_v | !s2_v | out_ready (combinational from out_ready only).
- Full throughput: one word per cycle when out_ready is held high.
- Capacity: 2 words. With out_ready low and both stages full, in_ready=0.
- Simultaneous input and output transfer with both stages full: S2←S1 and S1←input in the same edge; no bubble.
- Outputs instr/range_err remain stable while out_valid=1 and out_ready=0.
- Empty pipeline: out_valid=0, and instr holds its last value (not checked).

## Test plan
- I-type: base 0x00000013, imm=0xFFFFFFFF -> instr 0xFFF00013, range_err=0, out_valid two edges after acceptance.
- S/U-type:
  - base 0x00002023, imm=8 -> 0x00002423.
  - base 0x00000037, imm=0x12345000 -> 0x12345037.
  - Same with imm=0x12345001 -> range_err=1, err_count=1.
- B/J-type:
  - base 0x00000063, imm=0xFFFFFFFC -> 0xFE000EE3.
  - base 0x0000006F, imm=0x800 -> 0x0010006F.
  - B with imm=3 -> range_err=1.
- Range/invalid:
  - I with imm=2048 -> 0x80000013, range_err=1.
  - imm_type=111, base 0xDEADBEEF -> instr 0xDEADBEEF, range_err=1.
  - 260 consecutive errors -> err_count=255.
- Backpressure:
  - Hold out_ready=0 and offer 3 words -> in_ready falls after 2 accepted.
  - Release out_ready -> 3 words emerge in order, one per cycle, no loss or duplication.
- Reset mid-stream: assert reset with both stages full -> next cycle out_valid=0, err_count=0, in_ready=1; the old words never appear.
